// File: rtl/minmax_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : minmax_tracker
//  Description : Streaming min/max tracker for framed sample segments.
//                Records running minimum/maximum, their sample positions and
//                a saturating segment length. Finished results sit in a
//                valid/ready output register while the next segment
//                accumulates.
//  Revision    : 1.0 - initial release
// ============================================================================
module minmax_tracker #(
   parameter int DATA_W   = 8,
   parameter int IDX_W    = 11,
   parameter bit TIE_LAST = 1'b0
) (
   input  logic              module_clk,
   input  logic              module_rst_n,
   input  logic              din_val,
   input  logic              din_sof,
   input  logic              din_eof,
   input  logic [DATA_W-1:0] din_data,
   output logic              dout_val,
   input  logic              dout_rdy,
   output logic [DATA_W-1:0] dout_min,
   output logic [DATA_W-1:0] dout_max,
   output logic [IDX_W-1:0]  dout_min_idx,
   output logic [IDX_W-1:0]  dout_max_idx,
   output logic [IDX_W-1:0]  dout_cnt,
   output logic              err_drop,
   output logic              err_sof
);

   // Count saturates here; indices saturate with it since idx = current count.
   localparam logic [IDX_W-1:0] C_CNT_MAX = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] C_CNT_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   state_t             r_state;

   // Running accumulator for the segment in progress
   logic [DATA_W-1:0]  r_acc_min;
   logic [DATA_W-1:0]  r_acc_max;
   logic [IDX_W-1:0]   r_acc_min_idx;
   logic [IDX_W-1:0]   r_acc_max_idx;
   logic [IDX_W-1:0]   r_acc_cnt;

   // Output holding register
   logic               r_dout_val;
   logic [DATA_W-1:0]  r_dout_min;
   logic [DATA_W-1:0]  r_dout_max;
   logic [IDX_W-1:0]   r_dout_min_idx;
   logic [IDX_W-1:0]   r_dout_max_idx;
   logic [IDX_W-1:0]   r_dout_cnt;
   logic               r_err_drop;
   logic               r_err_sof;

   // Per-sample control decode
   logic               w_in_acc;
   logic               w_start;
   logic               w_cont;
   logic               w_done;
   logic               w_abort;
   logic               w_min_upd;
   logic               w_max_upd;
   logic [IDX_W-1:0]   w_cnt_inc;
   logic               w_out_busy;
   logic               w_load;
   logic               w_drop;

   // Accumulator values including the current sample (combined view)
   logic [DATA_W-1:0]  w_nxt_min;
   logic [DATA_W-1:0]  w_nxt_max;
   logic [IDX_W-1:0]   w_nxt_min_idx;
   logic [IDX_W-1:0]   w_nxt_max_idx;
   logic [IDX_W-1:0]   w_nxt_cnt;

   assign w_in_acc  = (r_state == ST_ACC);
   // A sof always (re)starts a segment, from IDLE or in the middle of one.
   assign w_start   = din_val & din_sof;
   assign w_cont    = din_val & ~din_sof & w_in_acc;
   // eof only completes a segment that actually exists (or starts now).
   assign w_done    = din_val & din_eof & (din_sof | w_in_acc);
   assign w_abort   = w_start & w_in_acc;
   assign w_cnt_inc = (r_acc_cnt == C_CNT_MAX) ? r_acc_cnt : (r_acc_cnt + C_CNT_ONE);

   // Tie rule picks strict or non-strict comparison; unsigned throughout.
   generate
      if (TIE_LAST) begin : g_tie_last
         assign w_min_upd = (din_data <= r_acc_min);
         assign w_max_upd = (din_data >= r_acc_max);
      end else begin : g_tie_first
         assign w_min_upd = (din_data < r_acc_min);
         assign w_max_upd = (din_data > r_acc_max);
      end
   endgenerate

   // Combine the current sample into the running accumulator values
   always_comb begin
      w_nxt_min     = r_acc_min;
      w_nxt_max     = r_acc_max;
      w_nxt_min_idx = r_acc_min_idx;
      w_nxt_max_idx = r_acc_max_idx;
      w_nxt_cnt     = r_acc_cnt;
      if (w_start) begin
         w_nxt_min     = din_data;
         w_nxt_max     = din_data;
         w_nxt_min_idx = '0;
         w_nxt_max_idx = '0;
         w_nxt_cnt     = C_CNT_ONE;
      end else if (w_cont) begin
         // The new sample's index is the count before it (already saturated).
         if (w_min_upd) begin
            w_nxt_min     = din_data;
            w_nxt_min_idx = r_acc_cnt;
         end
         if (w_max_upd) begin
            w_nxt_max     = din_data;
            w_nxt_max_idx = r_acc_cnt;
         end
         w_nxt_cnt = w_cnt_inc;
      end
   end

   // Output register is blocked only if it holds a result not taken this cycle.
   assign w_out_busy = r_dout_val & ~dout_rdy;
   assign w_load     = w_done & ~w_out_busy;
   assign w_drop     = w_done & w_out_busy;

   // Accumulator FSM: IDLE waits for sof, ACC folds samples in until eof
   always_ff @(posedge module_clk or negedge module_rst_n) begin
      if (!module_rst_n) begin
         r_state       <= ST_IDLE;
         r_acc_min     <= '0;
         r_acc_max     <= '0;
         r_acc_min_idx <= '0;
         r_acc_max_idx <= '0;
         r_acc_cnt     <= '0;
      end else begin
         r_acc_min     <= w_nxt_min;
         r_acc_max     <= w_nxt_max;
         r_acc_min_idx <= w_nxt_min_idx;
         r_acc_max_idx <= w_nxt_max_idx;
         r_acc_cnt     <= w_nxt_cnt;
         case (r_state)
            ST_IDLE: begin
               if (w_start && !w_done) begin
                  r_state <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (w_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output holding register with valid/ready handshake and error pulses
   always_ff @(posedge module_clk or negedge module_rst_n) begin
      if (!module_rst_n) begin
         r_dout_val     <= 1'b0;
         r_dout_min     <= '0;
         r_dout_max     <= '0;
         r_dout_min_idx <= '0;
         r_dout_max_idx <= '0;
         r_dout_cnt     <= '0;
         r_err_drop     <= 1'b0;
         r_err_sof      <= 1'b0;
      end else begin
         r_err_drop <= w_drop;
         r_err_sof  <= w_abort;
         if (w_load) begin
            // A load in the acceptance cycle keeps valid high with new data.
            r_dout_val     <= 1'b1;
            r_dout_min     <= w_nxt_min;
            r_dout_max     <= w_nxt_max;
            r_dout_min_idx <= w_nxt_min_idx;
            r_dout_max_idx <= w_nxt_max_idx;
            r_dout_cnt     <= w_nxt_cnt;
         end else if (r_dout_val && dout_rdy) begin
            r_dout_val <= 1'b0;
         end
      end
   end

   assign dout_val     = r_dout_val;
   assign dout_min     = r_dout_min;
   assign dout_max     = r_dout_max;
   assign dout_min_idx = r_dout_min_idx;
   assign dout_max_idx = r_dout_max_idx;
   assign dout_cnt     = r_dout_cnt;
   assign err_drop     = r_err_drop;
   assign err_sof      = r_err_sof;

endmodule
`default_nettype wire

// File: tb/tb_minmax_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_minmax_tracker
//  Description : Self-checking bench for minmax_tracker. Three instances
//                (default, last-tie, 3-bit index) share one input stream and
//                are compared every cycle against a segment-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_minmax_tracker;

   logic       module_clk = 1'b0;
   logic       module_rst_n = 1'b0;
   logic       din_val = 1'b0;
   logic       din_sof = 1'b0;
   logic       din_eof = 1'b0;
   logic [7:0] din_data = 8'h00;
   logic       dout_rdy = 1'b0;

   logic        o_val   [3];
   logic [7:0]  o_min   [3];
   logic [7:0]  o_max   [3];
   logic [10:0] o_min_i [3];
   logic [10:0] o_max_i [3];
   logic [10:0] o_cnt   [3];
   logic        o_drop  [3];
   logic        o_sof   [3];
   logic [2:0]  n_min_i;
   logic [2:0]  n_max_i;
   logic [2:0]  n_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: current segment's samples plus expected output register per DUT
   int seg_q[$];
   bit seg_active = 1'b0;
   bit e_val = 1'b0;
   bit e_drop = 1'b0;
   bit e_sof = 1'b0;
   int e_min[3];
   int e_max[3];
   int e_min_i[3];
   int e_max_i[3];
   int e_cnt[3];

   always #5 module_clk = ~module_clk;

   minmax_tracker #(.DATA_W(8), .IDX_W(11), .TIE_LAST(1'b0)) u_dut0 (
      .module_clk(module_clk), .module_rst_n(module_rst_n),
      .din_val(din_val), .din_sof(din_sof), .din_eof(din_eof), .din_data(din_data),
      .dout_val(o_val[0]), .dout_rdy(dout_rdy),
      .dout_min(o_min[0]), .dout_max(o_max[0]),
      .dout_min_idx(o_min_i[0]), .dout_max_idx(o_max_i[0]), .dout_cnt(o_cnt[0]),
      .err_drop(o_drop[0]), .err_sof(o_sof[0])
   );

   minmax_tracker #(.DATA_W(8), .IDX_W(11), .TIE_LAST(1'b1)) u_dut1 (
      .module_clk(module_clk), .module_rst_n(module_rst_n),
      .din_val(din_val), .din_sof(din_sof), .din_eof(din_eof), .din_data(din_data),
      .dout_val(o_val[1]), .dout_rdy(dout_rdy),
      .dout_min(o_min[1]), .dout_max(o_max[1]),
      .dout_min_idx(o_min_i[1]), .dout_max_idx(o_max_i[1]), .dout_cnt(o_cnt[1]),
      .err_drop(o_drop[1]), .err_sof(o_sof[1])
   );

   minmax_tracker #(.DATA_W(8), .IDX_W(3), .TIE_LAST(1'b0)) u_dut2 (
      .module_clk(module_clk), .module_rst_n(module_rst_n),
      .din_val(din_val), .din_sof(din_sof), .din_eof(din_eof), .din_data(din_data),
      .dout_val(o_val[2]), .dout_rdy(dout_rdy),
      .dout_min(o_min[2]), .dout_max(o_max[2]),
      .dout_min_idx(n_min_i), .dout_max_idx(n_max_i), .dout_cnt(n_cnt),
      .err_drop(o_drop[2]), .err_sof(o_sof[2])
   );

   assign o_min_i[2] = {8'b0, n_min_i};
   assign o_max_i[2] = {8'b0, n_max_i};
   assign o_cnt[2]   = {8'b0, n_cnt};

   function automatic bit tie_of(input int k);
      return (k == 1);
   endfunction

   function automatic int w_of(input int k);
      return (k == 2) ? 3 : 11;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scan the finished segment directly: positions saturate at the count limit
   task automatic compute_result(input int k);
      int lim;
      int lo;
      int hi;
      int li;
      int hix;
      int ix;
      lim = (1 << w_of(k)) - 1;
      lo = seg_q[0];
      hi = seg_q[0];
      li = 0;
      hix = 0;
      for (int i = 1; i < seg_q.size(); i++) begin
         ix = (i > lim) ? lim : i;
         if (tie_of(k) ? (seg_q[i] <= lo) : (seg_q[i] < lo)) begin
            lo = seg_q[i];
            li = ix;
         end
         if (tie_of(k) ? (seg_q[i] >= hi) : (seg_q[i] > hi)) begin
            hi = seg_q[i];
            hix = ix;
         end
      end
      e_min[k]   = lo;
      e_max[k]   = hi;
      e_min_i[k] = li;
      e_max_i[k] = hix;
      e_cnt[k]   = (seg_q.size() > lim) ? lim : seg_q.size();
   endtask

   task automatic model_clear();
      seg_q.delete();
      seg_active = 1'b0;
      e_val = 1'b0;
      e_drop = 1'b0;
      e_sof = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e_min[k] = 0; e_max[k] = 0; e_min_i[k] = 0; e_max_i[k] = 0; e_cnt[k] = 0;
      end
   endtask

   // Effect of one clock edge with the given inputs on the expected state
   task automatic model_update(input bit v, input bit s, input bit e, input int d, input bit r);
      bit done;
      bit accepted;
      done = 1'b0;
      accepted = e_val && r;
      e_drop = 1'b0;
      e_sof = 1'b0;
      if (v) begin
         if (s) begin
            if (seg_active) e_sof = 1'b1;
            seg_q.delete();
            seg_q.push_back(d);
            seg_active = 1'b1;
         end else if (seg_active) begin
            seg_q.push_back(d);
         end
         if (e && seg_active) begin
            done = 1'b1;
            seg_active = 1'b0;
         end
      end
      if (done) begin
         if (e_val && !r) begin
            e_drop = 1'b1;
         end else begin
            e_val = 1'b1;
            for (int k = 0; k < 3; k++) compute_result(k);
         end
      end else if (accepted) begin
         e_val = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d dout_val", k), 32'(o_val[k]), 32'(e_val));
         chk($sformatf("dut%0d err_drop", k), 32'(o_drop[k]), 32'(e_drop));
         chk($sformatf("dut%0d err_sof", k), 32'(o_sof[k]), 32'(e_sof));
         chk($sformatf("dut%0d dout_min", k), 32'(o_min[k]), e_min[k]);
         chk($sformatf("dut%0d dout_max", k), 32'(o_max[k]), e_max[k]);
         chk($sformatf("dut%0d dout_min_idx", k), 32'(o_min_i[k]), e_min_i[k]);
         chk($sformatf("dut%0d dout_max_idx", k), 32'(o_max_i[k]), e_max_i[k]);
         chk($sformatf("dut%0d dout_cnt", k), 32'(o_cnt[k]), e_cnt[k]);
      end
   endtask

   // Drive one cycle of inputs, advance the model, check after the edge
   task automatic step(input bit v, input bit s, input bit e, input int d, input bit r);
      din_val  = v;
      din_sof  = s;
      din_eof  = e;
      din_data = 8'(d);
      dout_rdy = r;
      model_update(v, s, e, d, r);
      @(posedge module_clk);
      #1;
      check_all();
   endtask

   initial begin
      bit rv;
      bit rs;
      bit re;
      bit rr;
      model_clear();
      repeat (2) @(posedge module_clk);
      #1;
      check_all();
      module_rst_n = 1'b1;

      // Segment 7,3,9,3,9,1 with first-tie rule
      step(1, 1, 0, 7, 1); step(1, 0, 0, 3, 1); step(1, 0, 0, 9, 1);
      step(1, 0, 0, 3, 1); step(1, 0, 0, 9, 1); step(1, 0, 1, 1, 1);
      chk("t1 val", 32'(o_val[0]), 1);
      chk("t1 min", 32'(o_min[0]), 1);
      chk("t1 min_idx", 32'(o_min_i[0]), 5);
      chk("t1 max", 32'(o_max[0]), 9);
      chk("t1 max_idx", 32'(o_max_i[0]), 2);
      chk("t1 cnt", 32'(o_cnt[0]), 6);
      step(0, 0, 0, 0, 1);
      chk("t1 val one cycle", 32'(o_val[0]), 0);

      // Same stream ending in 5, last-tie rule on instance 1
      step(1, 1, 0, 7, 1); step(1, 0, 0, 3, 1); step(1, 0, 0, 9, 1);
      step(1, 0, 0, 3, 1); step(1, 0, 0, 9, 1); step(1, 0, 1, 5, 1);
      chk("t2 min", 32'(o_min[1]), 3);
      chk("t2 min_idx", 32'(o_min_i[1]), 3);
      chk("t2 max", 32'(o_max[1]), 9);
      chk("t2 max_idx", 32'(o_max_i[1]), 4);
      chk("t2 cnt", 32'(o_cnt[1]), 6);
      step(0, 0, 0, 0, 1);

      // Single-sample segment
      step(1, 1, 1, 8'hA5, 1);
      chk("t3 min", 32'(o_min[0]), 32'hA5);
      chk("t3 max", 32'(o_max[0]), 32'hA5);
      chk("t3 cnt", 32'(o_cnt[0]), 1);
      step(0, 0, 0, 0, 1);

      // Drop while the output register is held
      step(1, 1, 0, 4, 0); step(1, 0, 1, 2, 0);
      step(1, 1, 1, 8, 0);
      chk("t4 err_drop", 32'(o_drop[0]), 1);
      chk("t4 kept min", 32'(o_min[0]), 2);
      chk("t4 kept max", 32'(o_max[0]), 4);
      chk("t4 kept cnt", 32'(o_cnt[0]), 2);
      step(0, 0, 0, 0, 0);
      chk("t4 err_drop single", 32'(o_drop[0]), 0);
      step(0, 0, 0, 0, 1);
      chk("t4 val falls", 32'(o_val[0]), 0);

      // Segment aborted by a new sof
      step(1, 1, 0, 5, 1); step(1, 0, 0, 6, 1);
      step(1, 1, 0, 1, 1);
      chk("t5 err_sof", 32'(o_sof[0]), 1);
      step(1, 0, 1, 2, 1);
      chk("t5 min", 32'(o_min[0]), 1);
      chk("t5 max_idx", 32'(o_max_i[0]), 1);
      chk("t5 cnt", 32'(o_cnt[0]), 2);

      // Ramp 0..9 saturates the 3-bit instance
      for (int i = 0; i < 10; i++) step(1, (i == 0), (i == 9), i, 1);
      chk("t6 cnt sat", 32'(o_cnt[2]), 7);
      chk("t6 max_idx sat", 32'(o_max_i[2]), 7);
      chk("t6 max", 32'(o_max[2]), 9);
      chk("t6 cnt full", 32'(o_cnt[0]), 10);

      // Reset in the middle of a segment while a result is pending
      step(1, 1, 0, 40, 0); step(1, 0, 0, 50, 0);
      module_rst_n = 1'b0;
      model_clear();
      #1;
      check_all();
      @(posedge module_clk);
      #1;
      check_all();
      module_rst_n = 1'b1;
      step(1, 0, 0, 3, 1);
      step(1, 0, 1, 3, 1);
      step(1, 1, 0, 60, 1); step(1, 0, 0, 20, 1); step(1, 0, 1, 90, 1);
      chk("t7 post-reset cnt", 32'(o_cnt[0]), 3);

      // Long segment saturating the 11-bit count
      for (int i = 0; i < 2100; i++) step(1, (i == 0), (i == 2099), $urandom_range(255), 1);
      chk("t8 cnt sat 11b", 32'(o_cnt[0]), 2047);

      // Random framed traffic with random back-pressure
      for (int i = 0; i < 4000; i++) begin
         rv = ($urandom_range(3) != 0);
         rs = ($urandom_range(5) == 0);
         re = ($urandom_range(4) == 0);
         rr = ($urandom_range(9) < 7);
         step(rv, rs, re, $urandom_range(255), rr);
      end
      step(0, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/minmax_tracker.md
# minmax_tracker

Parametrised streaming min/max tracker for the eye-tracking pixel and projection path. It consumes a framed sample stream (start-of-segment / end-of-segment markers) and records the running minimum, maximum, their sample positions and the segment length. Results are held in a double-buffered output register with a valid/ready handshake, so the next segment can accumulate while the previous result waits for the downstream threshold/eye-locator logic.

## Interface
Parameters:
- DATA_W, 8, sample width (unsigned)
- IDX_W, 11, index/count width
- TIE_LAST, 0, tie rule: 0 keeps the first occurrence of an equal extreme; 1 keeps the last

Ports:
- module_clk  in  1  clock
- module_rst_n  in  1  reset: asynchronous, active-low
- din_val  in  1  input sample valid
- din_sof  in  1  first sample of a segment; qualified by din_val
- din_eof  in  1  last sample of a segment; qualified by din_val
- din_data  in  DATA_W  sample value, unsigned
- dout_val  out  1  result valid; held until accepted
- dout_rdy  in  1  downstream ready
- dout_min  out  DATA_W  segment minimum
- dout_max  out  DATA_W  segment maximum
- dout_min_idx  out  IDX_W  index of the minimum (first sample = 0)
- dout_max_idx  out  IDX_W  index of the maximum
- dout_cnt  out  IDX_W  sample count, saturating
- err_drop  out  1  one-cycle pulse: finished result discarded because the output register was still occupied
- err_sof  out  1  one-cycle pulse: segment aborted by sof before eof

## Operation
- Accumulator FSM states: IDLE and ACC.
- IDLE: din_val without din_sof is ignored. din_val & din_sof loads min = max = din_data, min_idx = max_idx = 0, cnt = 1, then goes to ACC. If din_eof is also set, the 1-sample segment completes immediately.
- ACC, din_val & !din_sof: idx = current cnt (saturated) and cnt = cnt + 1, saturating at 2^IDX_W-1.
  - Minimum update: TIE_LAST=0 uses din_data < min; TIE_LAST=1 uses <=. Max is symmetric with > / >=.
  - Update uses the combined value, so an eof sample can itself be the extreme.
- ACC, din_val & din_sof: the current segment is discarded, err_sof pulses, and the accumulator restarts with this sample as in IDLE. The FSM stays in ACC, or completes if din_eof is set.
- Completion (din_val & din_eof): the final values, including the eof sample, are transferred to the output register, and the FSM returns to IDLE.
  - If the output register is occupied and not being accepted in that same cycle, the result is discarded and err_drop pulses; the old result is kept.
- Output register: dout_val rises on transfer and falls the cycle after dout_val & dout_rdy, unless a new transfer occurs that cycle, in which case dout_val stays 1 with the new data.
- Outputs do not change while dout_val=1 and dout_rdy=0.
- Unsigned comparison throughout. No arithmetic beyond the saturating count.
- Reset mid-segment: the accumulator is lost, the FSM goes to IDLE, and a pending result is lost. There is no err pulse.

## Timing
- Reset values: dout_val 0, dout_min 0, dout_max 0, dout_min_idx 0, dout_max_idx 0, dout_cnt 0, err_drop 0, err_sof 0. FSM in IDLE.
- Input accepted every cycle (no input back-pressure). Throughput is 1 sample/clk.
- Latency: eof sample at edge N gives dout_val = 1 with the result after edge N, i.e. visible in cycle N+1.
- Handshake completes on the edge where dout_val & dout_rdy. dout_rdy may be held high permanently.
- err_drop and err_sof are asserted in the cycle after the causing edge, for exactly one cycle.
- Back-to-back segments: eof at N and sof at N+1 are legal. eof & sof on consecutive samples of different segments need no idle cycle.

## Test plan
- Segment 7,3,9,3,9,1 with dout_rdy=1 and TIE_LAST=0 -> one cycle after eof: min=1 idx5, max=9 idx2, cnt=6, dout_val for 1 cycle.
- Same stream with TIE_LAST=1 and the last sample changed to 5 -> min=3 idx3, max=9 idx4, cnt=6.
- Single sample sof&eof, data 0xA5 -> min=max=0xA5, both idx 0, cnt=1.
- Segment A (4,2) eof with dout_rdy=0, then segment B (8) eof while still not ready -> err_drop pulses once, outputs stay min=2 max=4 cnt=2. Then dout_rdy=1 -> dout_val falls the next cycle.
- Segment 5,6 then sof 1 (no eof), then 2 eof -> err_sof pulse. Result: min=1 idx0, max=2 idx1, cnt=2.
- IDX_W=3, 10-sample ramp 0..9 -> cnt=7 (saturated), max=9 idx7, min=0 idx0. Then assert reset during the next segment -> all outputs 0, and a following segment is processed normally.
